serial_adder_ctrl: RTL

Bit-serial adder controller that reuses a single 1-bit `full_adder` instance to add two WIDTH-bit operands over WIDTH clock cycles, LSB first. It accepts an operand pair on a valid/ready request handshake, runs a sequencing state machine with a carry register and operand/result shift registers, and presents the result on a valid/ready response handshake. It sits between a requester (sequencer, testbench or CPU datapath) and the shared 1-bit adder cell. It trades latency for area against a ripple-carry array.

---
 rtl/serial_adder_pkg.sv | 21 ++
 rtl/serial_adder_ctrl_full_adder.sv | 15 +
 rtl/serial_adder_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and constants for the bit-serial adder controller.
package serial_adder_pkg;

  localparam int unsigned DEFAULT_WIDTH = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    RUN  = ST_RUN,
    DONE = ST_DONE
  } state_e;

  // Bit counter width; a 1-bit operand still needs a 1-bit counter.
  function automatic int unsigned cnt_width(input int unsigned w);
    return (w > 1) ? $clog2(w) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_ctrl_full_adder.sv
// Shared 1-bit full adder cell; the only arithmetic in the serial adder datapath.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  always_comb begin
    sum  = a ^ b ^ cin;
    cout = (a & b) | (cin & (a ^ b));
  end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: WIDTH-cycle LSB-first add through one full_adder.
// Define SERIAL_ADDER_SUB_EN to add the Sub port and subtraction support.
module serial_adder_ctrl
  import serial_adder_pkg::*;
#(
  parameter int unsigned WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             Sub,
`endif
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             busy
);

  localparam int unsigned CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             accept;
  logic             last_bit;
  logic [WIDTH-1:0] b_load;
  logic             carry_load;
  logic             fa_sum;
  logic             fa_cout;

  full_adder u_fa (
    .a    (a_q[0]),
    .b    (b_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // Subtraction is A + ~B + 1, so only the load values change.
  always_comb begin
`ifdef SERIAL_ADDER_SUB_EN
    b_load     = Sub ? ~B : B;
    carry_load = Sub ? 1'b1 : Cin;
`else
    b_load     = B;
    carry_load = Cin;
`endif
  end

  always_comb begin
    accept   = req_valid && (state_q == IDLE);
    last_bit = (cnt_q == CW'(WIDTH - 1));
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:    if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from state or taken straight from registers
  always_comb begin
    req_ready = (state_q == IDLE);
    rsp_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    Sum       = res_q;
    Cout      = carry_q;
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = A;
      b_d     = b_load;
      carry_d = carry_load;
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      a_d             = a_q >> 1;
      b_d             = b_q >> 1;
      res_d           = res_q >> 1;
      res_d[WIDTH-1]  = fa_sum;
      carry_d         = fa_cout;
      cnt_d           = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
